// File: rtl/vga_timing.sv
// Raster timing generator with split x/y counters (32-pixel column groups, 48-line row groups).
// All sync, blank and pulse outputs are registered from next-state counter values, so they line up with the counters.
module vga_timing #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29
) (
    input  logic       clk,
    input  logic       rst,
    output logic       hsync,
    output logic       vsync,
    output logic       blank,
    output logic [4:0] x_lo,
    output logic [5:0] x_hi,
    output logic [5:0] y_lo,
    output logic [4:0] y_hi,
    output logic       line_start,
    output logic       frame_start,
    output logic       vblank_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_ON   = H_ACTIVE + H_FP;
    localparam int HS_OFF  = HS_ON + H_SYNC;
    localparam int VS_ON   = V_ACTIVE + V_FP;
    localparam int VS_OFF  = VS_ON + V_SYNC;

    // Boundary values pre-split into (hi, lo) so every edge is a pair of small equality compares.
    localparam logic [5:0] X_END_HI  = 6'((H_TOTAL - 1) / 32);
    localparam logic [4:0] X_END_LO  = 5'((H_TOTAL - 1) % 32);
    localparam logic [4:0] Y_END_HI  = 5'((V_TOTAL - 1) / 48);
    localparam logic [5:0] Y_END_LO  = 6'((V_TOTAL - 1) % 48);
    localparam logic [5:0] HB_HI     = 6'(H_ACTIVE / 32);
    localparam logic [4:0] HB_LO     = 5'(H_ACTIVE % 32);
    localparam logic [5:0] HS_ON_HI  = 6'(HS_ON / 32);
    localparam logic [4:0] HS_ON_LO  = 5'(HS_ON % 32);
    localparam logic [5:0] HS_OFF_HI = 6'(HS_OFF / 32);
    localparam logic [4:0] HS_OFF_LO = 5'(HS_OFF % 32);
    localparam logic [4:0] VB_HI     = 5'(V_ACTIVE / 48);
    localparam logic [5:0] VB_LO     = 6'(V_ACTIVE % 48);
    localparam logic [4:0] VS_ON_HI  = 5'(VS_ON / 48);
    localparam logic [5:0] VS_ON_LO  = 6'(VS_ON % 48);
    localparam logic [4:0] VS_OFF_HI = 5'(VS_OFF / 48);
    localparam logic [5:0] VS_OFF_LO = 6'(VS_OFF % 48);

    logic [4:0] x_lo_s;
    logic [5:0] x_hi_s;
    logic [5:0] y_lo_s;
    logic [4:0] y_hi_s;
    logic       line_end_s;
    logic       y_last_s;
    logic       frame_end_s;
    logic       x_zero_s;
    logic       y_zero_s;
    logic       hsync_s;
    logic       vsync_s;
    logic       h_blank_s;
    logic       v_blank_s;
    logic       h_blank_r;
    logic       v_blank_r;

    // Next-state counters; out-of-range values count as "last" so they fall back to zero.
    always_comb begin
        x_lo_s      = x_lo + 5'd1;
        x_hi_s      = x_hi;
        y_lo_s      = y_lo;
        y_hi_s      = y_hi;
        line_end_s  = (x_hi > X_END_HI) || ((x_hi == X_END_HI) && (x_lo >= X_END_LO));
        y_last_s    = (y_hi > Y_END_HI) || ((y_hi == Y_END_HI) && (y_lo >= Y_END_LO));
        frame_end_s = line_end_s && y_last_s;
        if (line_end_s) begin
            x_lo_s = 5'd0;
            x_hi_s = 6'd0;
            if (y_last_s) begin
                y_lo_s = 6'd0;
                y_hi_s = 5'd0;
            end else if (y_lo >= 6'd47) begin
                y_lo_s = 6'd0;
                y_hi_s = y_hi + 5'd1;
            end else begin
                y_lo_s = y_lo + 6'd1;
            end
        end else if (x_lo == 5'd31) begin
            x_lo_s = 5'd0;
            x_hi_s = x_hi + 6'd1;
        end else begin
            x_hi_s = x_hi;
        end
    end

    // Sync and blank levels only change at boundary equalities on the next-state counters.
    always_comb begin
        x_zero_s = (x_hi_s == 6'd0) && (x_lo_s == 5'd0);
        y_zero_s = (y_hi_s == 5'd0) && (y_lo_s == 6'd0);

        if ((x_hi_s == HS_ON_HI) && (x_lo_s == HS_ON_LO)) begin
            hsync_s = 1'b0;
        end else if ((x_hi_s == HS_OFF_HI) && (x_lo_s == HS_OFF_LO)) begin
            hsync_s = 1'b1;
        end else begin
            hsync_s = hsync;
        end

        if ((y_hi_s == VS_ON_HI) && (y_lo_s == VS_ON_LO)) begin
            vsync_s = 1'b0;
        end else if ((y_hi_s == VS_OFF_HI) && (y_lo_s == VS_OFF_LO)) begin
            vsync_s = 1'b1;
        end else begin
            vsync_s = vsync;
        end

        if ((x_hi_s == HB_HI) && (x_lo_s == HB_LO)) begin
            h_blank_s = 1'b1;
        end else if (x_zero_s) begin
            h_blank_s = 1'b0;
        end else begin
            h_blank_s = h_blank_r;
        end

        if ((y_hi_s == VB_HI) && (y_lo_s == VB_LO)) begin
            v_blank_s = 1'b1;
        end else if (y_zero_s) begin
            v_blank_s = 1'b0;
        end else begin
            v_blank_s = v_blank_r;
        end
    end

    // State and output registers; reset shows the x = 0, y = 0 position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_lo         <= 5'd0;
            x_hi         <= 6'd0;
            y_lo         <= 6'd0;
            y_hi         <= 5'd0;
            frame_count  <= 8'd0;
            hsync        <= 1'b1;
            vsync        <= 1'b1;
            h_blank_r    <= 1'b0;
            v_blank_r    <= 1'b0;
            blank        <= 1'b0;
            line_start   <= 1'b1;
            frame_start  <= 1'b1;
            vblank_start <= 1'b0;
        end else begin
            x_lo         <= x_lo_s;
            x_hi         <= x_hi_s;
            y_lo         <= y_lo_s;
            y_hi         <= y_hi_s;
            frame_count  <= frame_end_s ? frame_count + 8'd1 : frame_count;
            hsync        <= hsync_s;
            vsync        <= vsync_s;
            h_blank_r    <= h_blank_s;
            v_blank_r    <= v_blank_s;
            blank        <= h_blank_s | v_blank_s;
            line_start   <= x_zero_s;
            frame_start  <= x_zero_s && y_zero_s;
            vblank_start <= x_zero_s && (y_hi_s == VB_HI) && (y_lo_s == VB_LO);
        end
    end

endmodule
